// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks.
//   state_t        FSM encoding for the sequential converter
//   BCD_MAX_DIGIT  largest legal BCD digit value
//   bcd_valid()    1 when a nibble is a legal BCD digit
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    function automatic logic bcd_valid(input logic [3:0] nibble);
        return (nibble <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step: result = acc*10 + digit.
//   acc     in   BIN_W  running accumulator
//   digit   in   4      BCD digit to append
//   result  out  BIN_W  acc*10+digit, truncated to BIN_W
module bcd_mac10 #(
    parameter int BIN_W = 7
) (
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] result
);

    localparam int EXT_W = BIN_W + 4;

    logic [EXT_W-1:0] acc_ext;

    assign acc_ext = EXT_W'(acc);

    // acc*10 as (acc<<3)+(acc<<1) at full width; callers keep acc small
    // enough that the truncation back to BIN_W never loses a bit.
    assign result = BIN_W'((acc_ext << 3) + (acc_ext << 1) + EXT_W'(digit));

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock (Horner).
//   clk      in   1         rising-edge clock
//   rst_n    in   1         synchronous reset, active low
//   start    in   1         request, sampled only in IDLE
//   in_bcd   in   4*DIGITS  packed BCD, MSD in the top nibble
//   out_bin  out  BIN_W     binary result, held until the next result
//   busy     out  1         high while converting
//   done     out  1         one-cycle pulse, out_bin/err valid
//   err      out  1         last request contained a non-BCD digit
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 2,
    localparam int BIN_W  = $clog2(10**DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state;
    logic [4*DIGITS-1:0] shreg;
    logic [BIN_W-1:0]    acc;
    logic [BIN_W-1:0]    acc_next;
    logic [CNT_W-1:0]    cnt;
    logic                all_valid;

    always_comb begin
        all_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(in_bcd[4*i +: 4])) all_valid = 1'b0;
        end
    end

    bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
        .acc    (acc),
        .digit  (shreg[4*DIGITS-1 -: 4]),
        .result (acc_next)
    );

    assign busy = (state == ST_CONV);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            out_bin <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (all_valid) begin
                            shreg <= in_bcd;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= ST_CONV;
                        end else begin
                            // Bad digit: report immediately, skip conversion.
                            out_bin <= '0;
                            err     <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_CONV: begin
                    acc   <= acc_next;
                    shreg <= shreg << 4;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(DIGITS - 1)) begin
                        out_bin <= acc_next;
                        err     <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] in_bcd;
    logic [6:0] out_bin;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    bcd_to_bin_seq #(.DIGITS(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_bcd  (in_bcd),
        .out_bin (out_bin),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bcd;
        int         bin;
        logic       err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance one rising edge, then settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one request; exp_lat = edges after accept until done is seen
    task automatic do_req(input logic [7:0] bcd, input int exp_bin,
                          input logic exp_err, input string tag);
        int lat;
        int busy_n;
        int exp_lat;
        exp_lat = exp_err ? 0 : 2;
        start   = 1'b1;
        in_bcd  = bcd;
        step();
        start   = 1'b0;
        in_bcd  = 8'hFF;
        lat     = 0;
        busy_n  = 0;
        while (!done && lat < 10) begin
            if (busy) busy_n++;
            step();
            lat++;
        end
        chk({tag, " done"}, int'(done), 1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy cycles"}, busy_n, exp_lat);
        chk({tag, " out_bin"}, int'(out_bin), exp_bin);
        chk({tag, " err"}, int'(err), int'(exp_err));
        step();
        chk({tag, " done pulse width"}, int'(done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h45, 45, 1'b0};
        vecs[1] = '{8'h99, 99, 1'b0};
        vecs[2] = '{8'h00,  0, 1'b0};
        vecs[3] = '{8'h07,  7, 1'b0};
        vecs[4] = '{8'h3A,  0, 1'b1};
        vecs[5] = '{8'h12, 12, 1'b0};
        vecs[6] = '{8'h90, 90, 1'b0};
        vecs[7] = '{8'hA0,  0, 1'b1};
        vecs[8] = '{8'h09,  9, 1'b0};
        vecs[9] = '{8'hFF,  0, 1'b1};

        rst_n  = 1'b0;
        start  = 1'b0;
        in_bcd = 8'h00;
        step();
        step();
        chk("reset out_bin", int'(out_bin), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        rst_n = 1'b1;
        step();

        // directed table
        for (int i = 0; i < 10; i++)
            do_req(vecs[i].bcd, vecs[i].bin, vecs[i].err, $sformatf("vec%0d", i));

        // start held high; input changes after acceptance
        start  = 1'b1;
        in_bcd = 8'h21;
        step();                                   // edge 0: accept 21
        chk("hold busy e0", int'(busy), 1);
        in_bcd = 8'h88;
        step();                                   // edge 1
        step();                                   // edge 2: done
        chk("hold done1", int'(done), 1);
        chk("hold first", int'(out_bin), 21);
        step();                                   // edge 3: idle
        chk("hold idle done", int'(done), 0);
        chk("hold idle busy", int'(busy), 0);
        step();                                   // edge 4: accept 88
        chk("hold reaccept busy", int'(busy), 1);
        start = 1'b0;
        step();
        step();
        chk("hold done2", int'(done), 1);
        chk("hold second", int'(out_bin), 88);
        step();

        // reset in the middle of a conversion
        start  = 1'b1;
        in_bcd = 8'h56;
        step();
        start  = 1'b0;
        rst_n  = 1'b0;
        step();
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst out_bin", int'(out_bin), 0);
        chk("midrst err", int'(err), 0);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 4; k++) begin
                step();
                if (done) seen++;
            end
            chk("midrst no done", seen, 0);
        end
        do_req(8'h56, 56, 1'b0, "after rst");

        // exhaustive sweep against a digit-wise model
        for (int v = 0; v < 256; v++) begin
            logic [7:0] code;
            int msd;
            int lsd;
            code = 8'(v);
            msd  = int'(code[7:4]);
            lsd  = int'(code[3:0]);
            if (msd <= 9 && lsd <= 9)
                do_req(code, 10*msd + lsd, 1'b0, $sformatf("sweep %02h", code));
            else
                do_req(code, 0, 1'b1, $sformatf("sweep %02h", code));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
